// File: rtl/data_sram_resp_pkg.sv
// Shared types and constants for the data SRAM responder: FSM encoding,
// wait-counter width, physical segment bases and the address range check.
package data_sram_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int LAT_W = 3;

  // Physical bases of the two low windows the datapath maps its segments onto.
  localparam logic [31:0] SEG0_PHYS_BASE = 32'h0000_0000;
  localparam logic [31:0] SEG1_PHYS_BASE = 32'h1000_0000;

  function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned addr_w);
    return (addr >> (addr_w + 32'd2)) != 32'd0;
  endfunction

endpackage

// File: rtl/sram_bytewe.sv
// Single-port word array: synchronous per-byte-lane writes, combinational read
// so the responder can capture the word on its commit edge.
module sram_bytewe #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [2**ADDR_W];

  // Byte-lane write port
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: serves M-stage requests from a byte-writable array
// after LATENCY wait states, stalling the pipeline until the access completes.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] OOR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  input  logic        longest_stall,
  output logic [31:0] data_sram_rdata,
  output logic        d_stall,
  output logic        oor_err
);

  localparam logic [LAT_W-1:0] CNT_INIT = (LATENCY > 32'd0) ? LAT_W'(LATENCY - 32'd1) : 3'd0;

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              oor_q, oor_d;
  logic              commit_s;
  logic              oor_s;
  logic [3:0]        mem_we_s;
  logic [31:0]       mem_rdata_s;
  logic [ADDR_W-1:0] idx_s;
  logic              addr_lsb_unused;

  assign idx_s           = data_sram_addr[ADDR_W+1:2];
  assign addr_lsb_unused = ^data_sram_addr[1:0];
  assign oor_s           = addr_out_of_range(data_sram_addr, ADDR_W);

  // Next-state logic; commit_s marks the edge on which the access takes effect
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_sram_en) begin
          if (LATENCY == 32'd0) begin
            state_d  = ST_DONE;
            commit_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A dropped request is an exception flush: abandon without touching memory
        if (!data_sram_en) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q == 3'd0) begin
          state_d  = ST_DONE;
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_DONE: begin
        // The frozen M stage still presents this request; holding here avoids replaying it
        if (longest_stall) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Commit-edge datapath: lane writes, read capture and the sticky range flag
  always_comb begin
    mem_we_s = (commit_s && !oor_s) ? data_sram_wen : 4'b0000;
    oor_d    = oor_q | (commit_s & oor_s);
    if (commit_s && (data_sram_wen == 4'b0000)) begin
      rdata_d = oor_s ? OOR_RDATA : mem_rdata_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // FSM and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= 32'd0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      oor_q   <= oor_d;
    end
  end

  sram_bytewe #(
    .ADDR_W(ADDR_W)
  ) u_sram_bytewe (
    .clk  (clk),
    .we   (mem_we_s),
    .idx  (idx_s),
    .wdata(data_sram_wdata),
    .rdata(mem_rdata_s)
  );

  assign d_stall         = rst & data_sram_en & (state_q != ST_DONE);
  assign data_sram_rdata = rdata_q;
  assign oor_err         = oor_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp: directed vector table, randomized
// accesses against a word-array model, and hand-written timing corner cases.
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, ls;
  logic [3:0]  wen;
  logic [31:0] addr, wdata, rdata;
  logic        d_stall, oor_err;
  logic        en0, ls0;
  logic [3:0]  wen0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        d_stall0, oor_err0;

  always #5 clk = ~clk;

  data_sram_resp #(.ADDR_W(12), .LATENCY(2), .OOR_RDATA(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .longest_stall(ls), .data_sram_rdata(rdata),
    .d_stall(d_stall), .oor_err(oor_err)
  );

  data_sram_resp #(.ADDR_W(12), .LATENCY(0), .OOR_RDATA(32'h0000_0000)) u_dut0 (
    .clk(clk), .rst(rst), .data_sram_en(en0), .data_sram_wen(wen0), .data_sram_addr(addr0),
    .data_sram_wdata(wdata0), .longest_stall(ls0), .data_sram_rdata(rdata0),
    .d_stall(d_stall0), .oor_err(oor_err0)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] model [int];
  bit          oor_seen = 1'b0;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  w;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_oor;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_oor(input logic [31:0] a);
    return a[31:14] != 18'd0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    logic [31:0] word;
    int k;
    if (is_oor(a)) return;
    k = int'(a[13:2]);
    word = model.exists(k) ? model[k] : 32'hxxxx_xxxx;
    for (int l = 0; l < 4; l++) if (w[l]) word[8*l +: 8] = d[8*l +: 8];
    model[k] = word;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (is_oor(a)) return 32'h0000_0000;
    return model[int'(a[13:2])];
  endfunction

  // One complete access on the LATENCY=2 instance, starting and ending in IDLE
  task automatic run_access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                            output int stall_cycles, output logic [31:0] rd, output logic oe);
    en = 1'b1; wen = w; addr = a; wdata = d;
    #1;
    stall_cycles = 0;
    while (d_stall === 1'b1 && stall_cycles < 20) begin
      stall_cycles++;
      step();
    end
    rd = rdata;
    oe = oor_err;
    en = 1'b0; wen = 4'b0000;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    int          sc;
    logic [31:0] rd;
    logic        oe;
    logic [31:0] a, d;
    logic [3:0]  w;

    rst = 1'b0; en = 1'b1; wen = 4'b0000; addr = 32'h10; wdata = 32'd0; ls = 1'b0;
    en0 = 1'b1; wen0 = 4'b0000; addr0 = 32'h10; wdata0 = 32'd0; ls0 = 1'b0;
    #2;
    check("reset d_stall", {31'd0, d_stall}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset oor_err", {31'd0, oor_err}, 32'd0);
    check("reset d_stall0", {31'd0, d_stall0}, 32'd0);
    check("reset rdata0", rdata0, 32'd0);
    en = 1'b0; en0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();

    vecs[0] = '{32'h0000_0000, 4'b1111, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    vecs[1] = '{32'h0000_0010, 4'b1111, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[2] = '{32'h0000_0010, 4'b0000, 32'h0000_0000, 32'h1234_5678, 1'b0};
    vecs[3] = '{32'h0000_0010, 4'b0010, 32'h0000_AB00, 32'h0000_0000, 1'b0};
    vecs[4] = '{32'h0000_0010, 4'b0000, 32'h0000_0000, 32'h1234_AB78, 1'b0};
    vecs[5] = '{32'h0001_0000, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'h0001_0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[7] = '{32'h0000_0000, 4'b0000, 32'h0000_0000, 32'hCAFE_F00D, 1'b1};
    vecs[8] = '{32'h0000_0013, 4'b0000, 32'h0000_0000, 32'h1234_AB78, 1'b1};
    vecs[9] = '{32'h0000_0020, 4'b1111, 32'h55AA_33CC, 32'h0000_0000, 1'b1};

    for (int i = 0; i < 10; i++) begin
      run_access(vecs[i].a, vecs[i].w, vecs[i].d, sc, rd, oe);
      check($sformatf("vec%0d stall_cycles", i), 32'(sc), 32'd3);
      if (vecs[i].w == 4'b0000) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d oor_err", i), {31'd0, oe}, {31'd0, vecs[i].exp_oor});
      model_write(vecs[i].a, vecs[i].w, vecs[i].d);
      if (is_oor(vecs[i].a)) oor_seen = 1'b1;
    end

    // Random phase: seed 16 words fully, then mixed reads/partial writes/out-of-range
    for (int k = 0; k < 16; k++) begin
      a = 32'h400 + 32'(k) * 32'd4;
      d = $urandom;
      run_access(a, 4'b1111, d, sc, rd, oe);
      model_write(a, 4'b1111, d);
      check($sformatf("init%0d stall_cycles", k), 32'(sc), 32'd3);
    end
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom;
        if (a[31:14] == 18'd0) a[31] = 1'b1;
      end else begin
        a = 32'h400 + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
      end
      w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      d = $urandom;
      run_access(a, w, d, sc, rd, oe);
      check($sformatf("rnd%0d stall_cycles", n), 32'(sc), 32'd3);
      if (w == 4'b0000) check($sformatf("rnd%0d rdata a=%h", n, a), rd, model_read(a));
      model_write(a, w, d);
      if (is_oor(a)) oor_seen = 1'b1;
      check($sformatf("rnd%0d oor_err", n), {31'd0, oe}, {31'd0, oor_seen});
    end

    // Request dropped mid-WAIT: the write to 0x20 must never land
    en = 1'b1; wen = 4'b1111; addr = 32'h20; wdata = 32'h1111_1111;
    #1;
    check("abort d_stall idle", {31'd0, d_stall}, 32'd1);
    step();
    en = 1'b0; wen = 4'b0000;
    step();
    run_access(32'h20, 4'b0000, 32'd0, sc, rd, oe);
    check("abort reread stall_cycles", 32'(sc), 32'd3);
    check("abort reread rdata", rd, 32'h55AA_33CC);

    // Read completing under longest_stall holds DONE for 4 cycles
    en = 1'b1; wen = 4'b0000; addr = 32'h10;
    #1;
    sc = 0;
    while (d_stall === 1'b1 && sc < 20) begin
      sc++;
      step();
    end
    check("ls stall_cycles", 32'(sc), 32'd3);
    check("ls rdata done", rdata, 32'h1234_AB78);
    ls = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("ls hold%0d d_stall", c), {31'd0, d_stall}, 32'd0);
      check($sformatf("ls hold%0d rdata", c), rdata, 32'h1234_AB78);
    end
    ls = 1'b0;
    #1;
    check("ls release d_stall", {31'd0, d_stall}, 32'd0);
    step();
    check("ls fresh access d_stall", {31'd0, d_stall}, 32'd1);
    sc = 0;
    while (d_stall === 1'b1 && sc < 20) begin
      sc++;
      step();
    end
    check("ls fresh remaining stall", 32'(sc), 32'd3);
    en = 1'b0;
    step();

    // LATENCY=0 instance: one-cycle stall, back-to-back reads of one address
    en0 = 1'b1; wen0 = 4'b1111; addr0 = 32'h40; wdata0 = 32'hA5A5_0F0F;
    #1;
    check("lat0 write d_stall", {31'd0, d_stall0}, 32'd1);
    step();
    check("lat0 write done d_stall", {31'd0, d_stall0}, 32'd0);
    en0 = 1'b0; wen0 = 4'b0000;
    step();
    en0 = 1'b1; addr0 = 32'h40;
    #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("lat0 b2b%0d d_stall", i), {31'd0, d_stall0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 1) check($sformatf("lat0 b2b%0d rdata", i), rdata0, 32'hA5A5_0F0F);
      step();
    end
    check("lat0 oor_err", {31'd0, oor_err0}, 32'd0);
    en0 = 1'b0;
    step();

    // Reset pulsed mid-WAIT clears outputs at once and the sticky flag
    check("pre-reset rdata", rdata, 32'h1234_AB78);
    check("pre-reset oor_err", {31'd0, oor_err}, 32'd1);
    en = 1'b1; wen = 4'b0000; addr = 32'h10;
    step();
    #2;
    rst = 1'b0;
    #1;
    check("midwait reset d_stall", {31'd0, d_stall}, 32'd0);
    check("midwait reset rdata", rdata, 32'd0);
    check("midwait reset oor_err", {31'd0, oor_err}, 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    run_access(32'h20, 4'b0000, 32'd0, sc, rd, oe);
    check("post-reset stall_cycles", 32'(sc), 32'd3);
    check("post-reset rdata", rd, 32'h55AA_33CC);
    check("post-reset oor_err", {31'd0, oe}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
Memory-side responder for the CPU data SRAM port. It accepts the datapath's M-stage request (memenM, data_sram_wenM, data_sram_waddr, data_sram_wdataM) and serves it from an internal byte-writable word array. The block inserts a programmable number of wait states and drives d_stall back to the hazard unit. It sits between the datapath and the memory, in the position a cache or AXI bridge will later take.

Parameters:
ADDR_W, 12, word-index width; the array holds 2^ADDR_W 32-bit words.
LATENCY, 2, wait cycles per access, legal range 0..7.
OOR_RDATA, 32'h0000_0000, read data returned for an out-of-range address.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset).
data_sram_en  in  1  request valid (memenM).
data_sram_wen  in  4  byte-lane write enables; 4'b0000 means read.
data_sram_addr  in  32  physical byte address, already translated by the datapath.
data_sram_wdata  in  32  write data, lane-aligned.
longest_stall  in  1  CPU-wide stall; the M stage is frozen for an unrelated reason.
data_sram_rdata  out  32  registered read data.
d_stall  out  1  holds the pipeline until the access completes.
oor_err  out  1  sticky flag, set by any out-of-range access.

Behaviour:
- Reset values: FSM = IDLE, data_sram_rdata = 0, oor_err = 0, wait counter = 0, d_stall = 0. The memory array is not reset.
- Reset is asynchronous and can assert mid-operation. It forces IDLE immediately. A pending write that has not reached the commit edge is dropped.
- States: IDLE, WAIT, DONE.
- IDLE:
  - en=1 and LATENCY>0: go to WAIT and load the counter with LATENCY-1.
  - en=1 and LATENCY=0: go straight to DONE, committing on this edge.
  - en=0: stay in IDLE.
- WAIT:
  - The counter decrements each cycle.
  - At counter=0, go to DONE and commit on this edge.
  - If en drops (exception flush), abort to IDLE with no commit.
- Commit edge:
  - Write: update only the lanes with wen[i]=1.
  - Read: capture the addressed word into data_sram_rdata.
  - Sub-word extraction and sign extension are done in the CPU's lsmem, not here.
- DONE:
  - d_stall = 0 and data_sram_rdata is held stable.
  - longest_stall=1: stay in DONE, because the same request is still presented and must not be re-executed.
  - longest_stall=0: go to IDLE.
- d_stall = en & (state != DONE). This is combinational and is forced 0 while rst=0.
- Latency seen by the CPU: d_stall is high for LATENCY+1 cycles after en rises (IDLE plus the WAIT cycles). data_sram_rdata is valid in the first DONE cycle. Each access occupies LATENCY+2 cycles from IDLE back to IDLE.
- Back-to-back requests: DONE always passes through IDLE. A new request presented the cycle after DONE is treated as a fresh access, even if the address is identical.
- Word index = addr[ADDR_W+1:2]. addr[1:0] is ignored; alignment exceptions are raised upstream.
- Out-of-range address: addr[31:ADDR_W+2] != 0.
  - The access completes with normal timing.
  - A write is dropped; a read returns OOR_RDATA.
  - oor_err is set at the commit edge and cleared only by reset.
- Simultaneous write and read in one access is impossible: a single request is either a read or a write.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit: IDLE=0, WAIT=1, DONE=2).
  - LATENCY width constant (3).
  - Physical segment constants for the 0x0 and 0x1 windows produced by the datapath's address mapping.
- One sub-module, sram_bytewe: a single-port, synchronous, 4-lane byte-write word array with ports clk, we[3:0], idx, wdata, rdata.
- The FSM, counter, range check and stall logic stay in data_sram_resp.

Test Plan:
- LATENCY=2; write 0x1234_5678 to addr 0x0000_0010 with wen=4'b1111, then read it back -> d_stall high for exactly 3 cycles on each access; rdata=0x1234_5678 in the read's DONE cycle.
- Byte write of wdata=0x0000_AB00 with wen=4'b0010 to the same word, then read -> rdata=0x1234_AB78; the other lanes are unchanged.
- LATENCY=0; read -> d_stall high for 1 cycle; rdata valid on the next cycle; back-to-back reads to the same address each take 2 cycles.
- Read completes while longest_stall=1 for 4 cycles -> FSM holds DONE, d_stall=0, rdata stable; no second access is issued; IDLE is entered the cycle after longest_stall falls.
- Write to 0x0000_0020 with en dropped mid-WAIT -> FSM returns to IDLE and a subsequent read of that word returns its old value. Separately, rst pulsed low mid-WAIT -> d_stall=0, rdata=0 immediately.
- Write to 0x0001_0000 (out of range for ADDR_W=12), then a read there -> the write is dropped and the read returns OOR_RDATA; oor_err=1 and stays 1 until reset.
